// File: rtl/banana_drop_controller.sv
// Enemy banana bomb sequencer: accepts a launch, drops the bomb one step per video frame,
// retires it on collision or at the screen bottom, then holds off re-fire for a cooldown.
module banana_drop_controller #(
   parameter int unsigned FALL_SPEED      = 4,
   parameter int unsigned SCREEN_BOTTOM   = 479,
   parameter int unsigned OBJECT_HEIGHT   = 32,
   parameter int unsigned HIT_HOLD_FRAMES = 8,
   parameter int unsigned COOLDOWN_FRAMES = 30
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        gameActive,
   input  logic        fireReq,
   input  logic [10:0] fireX,
   input  logic [10:0] fireY,
   input  logic        collision,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic        appear,
   output logic        fireAck,
   output logic        bananaHit,
   output logic        busy
);

   localparam int unsigned CntMax = (HIT_HOLD_FRAMES > COOLDOWN_FRAMES) ? HIT_HOLD_FRAMES
                                                                          : COOLDOWN_FRAMES;
   localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);

   localparam logic [CntW-1:0] HitLast  = CntW'(HIT_HOLD_FRAMES - 1);
   localparam logic [CntW-1:0] CoolLast = CntW'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);
   localparam logic [12:0]     BottomLimit = 13'(SCREEN_BOTTOM + 1);

   typedef enum logic [1:0] {StIdle, StFall, StHit, StCooldown} state_t;

   state_t          r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   logic [10:0]     r_x, w_x_nxt;
   logic [10:0]     r_y, w_y_nxt;
   logic            r_ack, w_ack_nxt;
   logic            r_hit, w_hit_nxt;
   logic            r_appear, r_busy;

   logic [11:0]     w_next_y;
   logic [12:0]     w_next_bottom;
   logic            w_past_bottom;

   // Candidate step is widened so a launch near the 11-bit ceiling cannot wrap.
   assign w_next_y      = {1'b0, r_y} + 12'(FALL_SPEED);
   assign w_next_bottom = {1'b0, w_next_y} + 13'(OBJECT_HEIGHT);
   assign w_past_bottom = (w_next_bottom > BottomLimit);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_ack_nxt   = 1'b0;
      w_hit_nxt   = 1'b0;

      if (!gameActive) begin
         w_state_nxt = StIdle;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (fireReq) begin
                  w_x_nxt     = fireX;
                  w_y_nxt     = fireY;
                  w_ack_nxt   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = StFall;
               end
            end
            StFall: begin
               if (collision) begin
                  w_hit_nxt   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = StHit;
               end else if (startOfFrame) begin
                  if (w_past_bottom) begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = StCooldown;
                  end else begin
                     w_y_nxt = w_next_y[10:0];
                  end
               end
            end
            StHit: begin
               if (startOfFrame) begin
                  if (r_cnt == HitLast) begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = StCooldown;
                  end else begin
                     w_cnt_nxt = r_cnt + CntW'(1);
                  end
               end
            end
            StCooldown: begin
               if (COOLDOWN_FRAMES == 0) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = StIdle;
               end else if (startOfFrame) begin
                  if (r_cnt == CoolLast) begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = StIdle;
                  end else begin
                     w_cnt_nxt = r_cnt + CntW'(1);
                  end
               end
            end
            default: begin
               w_cnt_nxt   = '0;
               w_state_nxt = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_ack    <= 1'b0;
         r_hit    <= 1'b0;
         r_appear <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_ack    <= w_ack_nxt;
         r_hit    <= w_hit_nxt;
         // Registered from the next state so appear/busy track the state on the same edge.
         r_appear <= (w_state_nxt == StFall);
         r_busy   <= (w_state_nxt != StIdle);
      end
   end

   assign topLeftX  = r_x;
   assign topLeftY  = r_y;
   assign appear    = r_appear;
   assign fireAck   = r_ack;
   assign bananaHit = r_hit;
   assign busy      = r_busy;

endmodule

// File: tb/tb_banana_drop_controller.sv
// Scoreboard bench: flights are planned from the drop rules, expected events are queued,
// and a monitor matches every ack / hit / bottom-retire / return-to-idle the DUT shows.
module tb_banana_drop_controller;

   localparam int FallSpeed  = 4;
   localparam int Limit      = 480 - 32;   // highest top-left Y that still fits on screen
   localparam int HitHold    = 8;
   localparam int Cooldown   = 30;

   localparam int EvAck    = 0;
   localparam int EvHit    = 1;
   localparam int EvBottom = 2;
   localparam int EvIdle   = 3;

   localparam int ModeBottom    = 0;
   localparam int ModeCollide   = 1;
   localparam int ModeAbortFall = 2;
   localparam int ModeAbortCool = 3;
   localparam int ModeReset     = 4;

   logic        clk = 1'b0;
   logic        resetN, startOfFrame, gameActive, fireReq, collision;
   logic [10:0] fireX, fireY;
   logic [10:0] topLeftX, topLeftY;
   logic        appear, fireAck, bananaHit, busy;

   banana_drop_controller dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .gameActive   (gameActive),
      .fireReq      (fireReq),
      .fireX        (fireX),
      .fireY        (fireY),
      .collision    (collision),
      .topLeftX     (topLeftX),
      .topLeftY     (topLeftY),
      .appear       (appear),
      .fireAck      (fireAck),
      .bananaHit    (bananaHit),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int x;
      int y;
      int frames;
      int cyc;
      bit chk_frames;
      bit chk_cyc;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic push_ev(input int kind, input int x, input int y, input int frames,
                          input int cyc, input bit cf, input bit cc);
      ev_t e;
      e.kind = kind; e.x = x; e.y = y; e.frames = frames; e.cyc = cyc;
      e.chk_frames = cf; e.chk_cyc = cc;
      exp_q.push_back(e);
   endtask

   // Number of whole steps a bomb launched at y can take before the next step would overrun.
   function automatic int moves_to_bottom(input int y);
      return (y <= Limit) ? (Limit - y) / FallSpeed : 0;
   endfunction

   // Monitor: classifies what the DUT shows after each edge and pops the scoreboard.
   task automatic match(input int kind, input int frames, input int cyc);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("spurious_event", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_x", int'(topLeftX), e.x);
         chk("event_y", int'(topLeftY), e.y);
         if (e.chk_frames) chk("event_frames", frames, e.frames);
         if (e.chk_cyc) chk("event_cycles", cyc, e.cyc);
      end
   endtask

   initial begin
      int   frames = 0;
      int   cyc    = 0;
      int   kind;
      logic sof_s;
      logic prev_appear = 1'b0;
      logic prev_busy   = 1'b0;
      forever begin
         @(posedge clk);
         sof_s = startOfFrame;
         #1;
         cyc++;
         if (sof_s === 1'b1) frames++;
         kind = -1;
         if (prev_busy && !busy) kind = EvIdle;
         else if (bananaHit) kind = EvHit;
         else if (prev_appear && !appear) kind = EvBottom;
         if (fireAck) begin
            match(EvAck, frames, cyc);
            frames = 0; cyc = 0;
         end
         if (kind != -1) begin
            match(kind, frames, cyc);
            frames = 0; cyc = 0;
         end
         prev_appear = appear;
         prev_busy   = busy;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, pending events %0d", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   // Issues n frame pulses, each after 0..2 quiet cycles; noise sprinkles ignorable collisions.
   task automatic pulses(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            startOfFrame = 1'b0;
            collision    = noise & $urandom_range(0, 1);
         end
         @(negedge clk);
         startOfFrame = 1'b1;
         collision    = noise & $urandom_range(0, 1);
      end
      @(negedge clk);
      startOfFrame = 1'b0;
      collision    = 1'b0;
   endtask

   task automatic fly(input int x, input int y, input int mode, input int k, input bit sof_col,
                      input bit pre_acked, input bit hold_next, input int nx, input int ny);
      int m, kk, yf;
      m  = moves_to_bottom(y);
      kk = (k > m) ? m : k;
      if (!pre_acked) begin
         push_ev(EvAck, x, y, 0, 0, 1'b0, 1'b0);
         @(negedge clk);
         fireReq = 1'b1;
         fireX   = 11'(x);
         fireY   = 11'(y);
      end
      @(posedge clk);
      #1;
      chk("launch_appear", int'(appear), 1);
      chk("launch_busy", int'(busy), 1);
      chk("launch_x", int'(topLeftX), x);
      chk("launch_y", int'(topLeftY), y);
      @(negedge clk);
      if (hold_next) begin
         fireX = 11'(nx);
         fireY = 11'(ny);
      end else begin
         fireReq = 1'b0;
      end

      case (mode)
         ModeBottom: begin
            yf = y + FallSpeed * m;
            push_ev(EvBottom, x, yf, m + 1, 0, 1'b1, 1'b0);
            push_ev(EvIdle, x, yf, Cooldown, 0, 1'b1, 1'b0);
         end
         ModeCollide: begin
            yf = y + FallSpeed * kk;
            push_ev(EvHit, x, yf, kk + int'(sof_col), 0, 1'b1, 1'b0);
            push_ev(EvIdle, x, yf, HitHold + Cooldown, 0, 1'b1, 1'b0);
         end
         ModeAbortFall: push_ev(EvIdle, x, y + FallSpeed * kk, 0, 0, 1'b0, 1'b0);
         ModeAbortCool: begin
            yf = y + FallSpeed * m;
            push_ev(EvBottom, x, yf, m + 1, 0, 1'b1, 1'b0);
            push_ev(EvIdle, x, yf, 0, 0, 1'b0, 1'b0);
         end
         default: push_ev(EvIdle, 0, 0, 0, 0, 1'b0, 1'b0);
      endcase
      if (hold_next) push_ev(EvAck, nx, ny, 0, 1, 1'b0, 1'b1);

      case (mode)
         ModeBottom: begin
            pulses(m + 1, 1'b0);
            pulses(Cooldown, 1'b1);
         end
         ModeCollide: begin
            pulses(kk, 1'b0);
            chk("y_before_hit", int'(topLeftY), y + FallSpeed * kk);
            @(negedge clk);
            collision    = 1'b1;
            startOfFrame = sof_col;
            @(negedge clk);
            collision    = 1'b0;
            startOfFrame = 1'b0;
            #1;
            chk("hit_appear_low", int'(appear), 0);
            pulses(HitHold + Cooldown, 1'b1);
         end
         ModeAbortFall, ModeAbortCool: begin
            if (mode == ModeAbortFall) begin
               pulses(kk, 1'b0);
            end else begin
               pulses(m + 1, 1'b0);
               pulses(k % Cooldown, 1'b1);
            end
            @(negedge clk);
            gameActive = 1'b0;
            @(negedge clk);
            gameActive = 1'b1;
            chk("abort_busy", int'(busy), 0);
            chk("abort_appear", int'(appear), 0);
         end
         default: begin
            pulses(kk, 1'b0);
            @(negedge clk);
            resetN = 1'b0;
            #1;
            chk("rst_x", int'(topLeftX), 0);
            chk("rst_y", int'(topLeftY), 0);
            chk("rst_flags", int'({appear, busy, fireAck, bananaHit}), 0);
            repeat (3) @(negedge clk);
            resetN = 1'b1;
         end
      endcase
   endtask

   initial begin
      int mode, y, m;
      bit hold, pend;
      int nx, ny, cx, cy;
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      gameActive   = 1'b1;
      fireReq      = 1'b0;
      collision    = 1'b0;
      fireX        = '0;
      fireY        = '0;
      #2;
      chk("reset_x", int'(topLeftX), 0);
      chk("reset_y", int'(topLeftY), 0);
      chk("reset_flags", int'({appear, busy, fireAck, bananaHit}), 0);
      repeat (2) @(negedge clk);
      resetN = 1'b1;

      fly(100, 50, ModeCollide, 10, 1'b0, 1'b0, 1'b0, 0, 0);
      fly(300, 440, ModeBottom, 0, 1'b0, 1'b0, 1'b0, 0, 0);
      fly(200, 180, ModeCollide, 5, 1'b1, 1'b0, 1'b0, 0, 0);
      fly(10, 400, ModeBottom, 0, 1'b0, 1'b0, 1'b1, 20, 420);
      fly(20, 420, ModeCollide, 3, 1'b0, 1'b1, 1'b1, 30, 1500);
      fly(30, 1500, ModeBottom, 0, 1'b0, 1'b1, 1'b0, 0, 0);
      fly(7, 300, ModeAbortFall, 4, 1'b0, 1'b0, 1'b0, 0, 0);
      fly(8, 430, ModeAbortCool, 10, 1'b0, 1'b0, 1'b0, 0, 0);
      fly(9, 350, ModeReset, 2, 1'b0, 1'b0, 1'b0, 0, 0);
      fly(11, 447, ModeBottom, 0, 1'b0, 1'b0, 1'b0, 0, 0);

      // A request while the game is stopped must not be acknowledged.
      @(negedge clk);
      gameActive = 1'b0;
      fireReq    = 1'b1;
      repeat (3) @(negedge clk);
      fireReq    = 1'b0;
      gameActive = 1'b1;

      pend = 1'b0;
      cx   = 0;
      cy   = 0;
      for (int i = 0; i < 20; i++) begin
         mode = $urandom_range(0, 4);
         if (!pend) begin
            cx = $urandom_range(0, 2047);
            cy = ($urandom_range(0, 7) == 0) ? $urandom_range(449, 2047) : $urandom_range(330, 460);
         end
         m    = moves_to_bottom(cy);
         hold = (mode != ModeReset) && (i != 19) && ($urandom_range(0, 2) == 0);
         nx   = $urandom_range(0, 2047);
         ny   = $urandom_range(330, 460);
         y    = $urandom_range(0, m);
         fly(cx, cy, mode, (mode == ModeAbortCool) ? $urandom_range(0, 29) : y,
             1'($urandom_range(0, 1)), pend, hold, nx, ny);
         pend = hold;
         cx   = nx;
         cy   = ny;
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
